// File: rtl/fetch_unit_if.sv
// Fetch unit control/bus bundle.
// master = sequencer side, slave = fetch unit.
interface fetch_unit_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Halt;
  logic             Jump_en;
  logic             Branch_taken;
  logic [PC_W-1:0]  Target;
  logic [PC_W-1:0]  PC;
  logic             Running;
  logic             Done;
  logic [CNT_W-1:0] Instr_cnt;

  modport master (
    output Start, Halt, Jump_en,
    output Branch_taken, Target,
    input  PC, Running, Done, Instr_cnt
  );

  modport slave (
    input  Start, Halt, Jump_en,
    input  Branch_taken, Target,
    output PC, Running, Done, Instr_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter sequencer: IDLE/RUN/DONE FSM,
// absolute redirects, saturating instruction count.
module fetch_unit #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input logic        Clk,
  input logic        Reset,
  fetch_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [PC_W-1:0] START =
    PC_W'(START_ADDR);

  logic [1:0]       state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= START;
      cnt   <= '0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          pc <= START;
          if (bus.Start) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        state == RUN: begin
          // Halt edge still counts as executed
          if (cnt != '1)
            cnt <= cnt + CNT_W'(1);
          if (bus.Halt)
            state <= DONE;
          else if (bus.Jump_en ||
                   bus.Branch_taken)
            pc <= bus.Target;
          else
            pc <= pc + PC_W'(1);
        end
        state == DONE: begin
          if (bus.Start) begin
            state <= RUN;
            pc    <= START;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.PC        = pc;
  assign bus.Instr_cnt = cnt;
  assign bus.Running   = (state == RUN);
  assign bus.Done      = (state == DONE);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table
// plus hand sequences for done/saturation/reset.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, halt, jmp, br;
  logic [9:0] tgt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(10), .CNT_W(16)) b16 ();
  fetch_unit_if #(.PC_W(10), .CNT_W(4))  b4  ();

  assign b16.Start        = start;
  assign b16.Halt         = halt;
  assign b16.Jump_en      = jmp;
  assign b16.Branch_taken = br;
  assign b16.Target       = tgt;
  assign b4.Start         = start;
  assign b4.Halt          = halt;
  assign b4.Jump_en       = jmp;
  assign b4.Branch_taken  = br;
  assign b4.Target        = tgt;

  fetch_unit #(.PC_W(10), .START_ADDR(0),
               .CNT_W(16)) dut (
    .Clk(clk), .Reset(rst), .bus(b16));

  fetch_unit #(.PC_W(10), .START_ADDR(0),
               .CNT_W(4)) dut4 (
    .Clk(clk), .Reset(rst), .bus(b4));

  typedef struct {
    logic       start, halt, jmp, br;
    logic [9:0] tgt;
    logic [9:0] pc;
    logic       run, done;
    int         cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(string n, int act,
                     int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               n, act, exp);
    end
  endtask

  task automatic drive(logic s, logic h,
                       logic j, logic b,
                       logic [9:0] t);
    start = s; halt = h;
    jmp = j; br = b; tgt = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(string n,
      logic [9:0] pc, logic run,
      logic done, int cnt);
    chk({n, ".pc"}, int'(b16.PC), int'(pc));
    chk({n, ".run"}, int'(b16.Running),
        int'(run));
    chk({n, ".done"}, int'(b16.Done),
        int'(done));
    chk({n, ".cnt"}, int'(b16.Instr_cnt),
        cnt);
    chk({n, ".cnt4"}, int'(b4.Instr_cnt),
        cnt > 15 ? 15 : cnt);
  endtask

  task automatic add(logic s, logic h,
      logic j, logic b, logic [9:0] t,
      logic [9:0] pc, logic r, logic d,
      int c);
    vec_t v;
    v.start = s; v.halt = h; v.jmp = j;
    v.br = b; v.tgt = t; v.pc = pc;
    v.run = r; v.done = d; v.cnt = c;
    vq.push_back(v);
  endtask

  initial begin
    logic [9:0] pc_hold;
    int         cnt_hold;

    // start, 5 sequential, redirects
    add(1,0,0,0,10'h000, 10'h000,1,0, 0);
    add(0,0,0,0,10'h000, 10'h001,1,0, 1);
    add(0,0,0,0,10'h000, 10'h002,1,0, 2);
    add(0,0,0,0,10'h000, 10'h003,1,0, 3);
    add(0,0,0,0,10'h000, 10'h004,1,0, 4);
    add(0,0,0,0,10'h000, 10'h005,1,0, 5);
    add(0,0,1,0,10'h003, 10'h003,1,0, 6);
    add(0,0,1,0,10'h040, 10'h040,1,0, 7);
    add(0,0,0,0,10'h000, 10'h041,1,0, 8);
    add(0,0,0,1,10'h010, 10'h010,1,0, 9);
    add(1,0,0,0,10'h000, 10'h011,1,0,10);
    add(0,0,1,0,10'h006, 10'h006,1,0,11);
    add(0,0,0,0,10'h000, 10'h007,1,0,12);
    // halt beats jump
    add(0,1,1,0,10'h020, 10'h007,0,1,13);
    add(0,1,1,0,10'h055, 10'h007,0,1,13);
    add(0,0,0,1,10'h099, 10'h007,0,1,13);
    // restart, then wrap
    add(1,0,0,0,10'h000, 10'h000,1,0, 0);
    add(0,0,1,0,10'h3FF, 10'h3FF,1,0, 1);
    add(0,0,0,0,10'h000, 10'h000,1,0, 2);
    add(0,0,0,0,10'h000, 10'h001,1,0, 3);

    rst = 1'b1;
    drive(1,1,1,1,10'h3AA);
    step();
    expect_all("reset", 10'h000, 0, 0, 0);
    rst = 1'b0;
    drive(0,1,1,1,10'h155);
    step();
    step();
    expect_all("idle_ignore", 10'h000, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].halt,
            vq[i].jmp, vq[i].br, vq[i].tgt);
      step();
      expect_all($sformatf("vec%0d", i),
                 vq[i].pc, vq[i].run,
                 vq[i].done, vq[i].cnt);
    end

    // run to halt, then random in DONE
    drive(0,0,1,0,10'h007);
    step();
    drive(0,1,0,0,10'h000);
    step();
    pc_hold  = 10'h007;
    cnt_hold = 5;
    expect_all("halt2", pc_hold, 0, 1, cnt_hold);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'($urandom), 1'($urandom),
            1'($urandom), 10'($urandom));
      step();
      expect_all($sformatf("done_rand%0d", i),
                 pc_hold, 0, 1, cnt_hold);
    end

    // reset from DONE
    rst = 1'b1;
    drive(0,0,0,0,10'h000);
    step();
    rst = 1'b0;
    expect_all("rst_done", 10'h000, 0, 0, 0);

    // saturation over 20 run cycles
    drive(1,0,0,0,10'h000);
    step();
    drive(0,0,0,0,10'h000);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat4_%0d", i),
          int'(b4.Instr_cnt),
          i > 15 ? 15 : i);
    end
    chk("sat16", int'(b16.Instr_cnt), 20);
    chk("sat_pc", int'(b16.PC), 20);

    // reset with start at PC 0x12
    drive(0,0,1,0,10'h012);
    step();
    chk("pc12", int'(b16.PC), 18);
    rst = 1'b1;
    drive(1,0,0,0,10'h000);
    step();
    rst = 1'b0;
    drive(0,0,0,0,10'h000);
    expect_all("rst_run", 10'h000, 0, 0, 0);
    step();
    expect_all("post_rst", 10'h000, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning program counter width in bits.
REQ-002 The block SHALL have parameter START_ADDR, default 0, meaning the PC value loaded on reset and on each Start.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the executed-instruction counter width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port Clk  input  1  system clock; all state updates on its rising edge.
REQ-006 Port Reset  input  1  synchronous, active-high reset.
REQ-007 Port Start  input  1  begin program execution from START_ADDR.
REQ-008 Port Halt  input  1  the current instruction is the program-terminating instruction.
REQ-009 Port Jump_en  input  1  unconditional jump, driven by the control decoder.
REQ-010 Port Branch_taken  input  1  conditional branch resolved true, driven by the ALU or decoder.
REQ-011 Port Target  input  PC_W  absolute destination address from the jump lookup table.
REQ-012 Port PC  output  PC_W  current instruction address presented to the instruction ROM.
REQ-013 Port Running  output  1  high while the current PC is a valid instruction being executed.
REQ-014 Port Done  output  1  program finished; held high until the next Start.
REQ-015 Port Instr_cnt  output  CNT_W  number of instructions executed in the current run.

Function
REQ-016 The block SHALL implement a three-state FSM:
- IDLE (encoding 0)
- RUN (encoding 1)
- DONE (encoding 2)
- unused encodings SHALL transition to IDLE on the next edge.
REQ-017 Running SHALL be 1 exactly when the state is RUN; Done SHALL be 1 exactly when the state is DONE; both are registered-state decodes with no combinational input paths.
REQ-018 IDLE: PC SHALL hold START_ADDR and Instr_cnt SHALL hold its value; Start=1 SHALL move the state to RUN, load PC with START_ADDR and clear Instr_cnt.
REQ-019 RUN: the block SHALL apply, per edge and in this priority order:
- Halt=1: go to DONE, hold PC.
- Jump_en=1 or Branch_taken=1: PC <= Target.
- otherwise: PC <= PC+1 modulo 2^PC_W.
REQ-020 RUN, wrap-around: PC = 2^PC_W-1 with no redirect SHALL wrap to 0 and remain in RUN.
REQ-021 RUN, instruction counting: Instr_cnt SHALL increment by 1 on every RUN edge, including the Halt edge, and SHALL saturate at 2^CNT_W-1.
REQ-022 RUN, Start: Start=1 SHALL be ignored.
REQ-023 RUN, simultaneous Halt with Jump_en or Branch_taken: Halt SHALL win; PC is unchanged.
REQ-024 DONE: PC and Instr_cnt SHALL hold; Halt, Jump_en, Branch_taken and Target SHALL be ignored.
REQ-025 DONE, Start=1: the state SHALL move to RUN, PC SHALL load START_ADDR and Instr_cnt SHALL clear, all on the same edge.
REQ-026 IDLE: Jump_en, Branch_taken and Halt SHALL have no effect.
REQ-027 Latency: a redirect or increment SHALL be visible on PC exactly one clock after the edge that samples it; there SHALL be no delay slot or bubble.
REQ-028 Target SHALL be used unmodified as an absolute address, with no offset arithmetic.

Reset
REQ-029 With Reset=1 at a rising edge, the block SHALL set state=IDLE, PC=START_ADDR, Instr_cnt=0, Running=0 and Done=0.
REQ-030 Reset SHALL take priority over every other input, including Start asserted on the same edge.
REQ-031 Reset asserted during RUN or DONE SHALL abort immediately with the same values as REQ-029.
REQ-032 After Reset deasserts, the block SHALL stay in IDLE until Start.

Verification
REQ-033 Sequential run: Reset, then Start for 1 cycle, then 5 idle cycles -> PC sequence 0,1,2,3,4,5; Running=1; Instr_cnt=5.
REQ-034 Redirect: at PC=3, Jump_en=1 with Target=0x40 -> next PC=0x40; at PC=0x41, Branch_taken=1 with Target=0x10 -> next PC=0x10.
REQ-035 Halt priority: at PC=7, Halt=1, Jump_en=1, Target=0x20 -> state DONE, PC stays 7, Done=1, Running=0; Done holds for 10 cycles under random inputs.
REQ-036 Wrap and saturation: PC=0x3FF with no redirect -> next PC=0x000; with CNT_W=4, 20 RUN cycles -> Instr_cnt=15.
REQ-037 Restart: from DONE, Start=1 -> next cycle PC=0, Instr_cnt=0, Running=1; Start pulsed during RUN -> no change to PC sequence.
REQ-038 Reset mid-run: Reset at PC=0x12 with Start=1 on the same edge -> state IDLE, PC=0, Instr_cnt=0, Done=0, Running=0.
